// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op encoding, flag bit positions and FSM states for alu_seq
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'd0,
      OP_OR   = 4'd1,
      OP_XOR  = 4'd2,
      OP_NOT  = 4'd3,
      OP_ADD  = 4'd4,
      OP_ADDC = 4'd5,
      OP_SUB  = 4'd6,
      OP_CMP  = 4'd7,
      OP_MOV  = 4'd8,
      OP_LSH  = 4'd9,
      OP_RSH  = 4'd10,
      OP_ARSH = 4'd11,
      OP_MUL  = 4'd12
   } op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   localparam int FLAG_L = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 4;

endpackage

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - bit-serial shifter and shift-add multiplier (multiplier only with ALU_MUL_EN)
module alu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [3:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [SHW-1:0]   i_amt,
`ifdef ALU_MUL_EN
   input  logic [WIDTH-1:0] i_mplier,
`endif
   output logic             o_last,
   output logic             o_is_mul,
   output logic [WIDTH-1:0] o_result,
   output logic             o_hi_nz
);

   // One extra counter bit so a WIDTH-step multiply fits alongside shift amounts.
   localparam int CW = SHW + 1;

   logic [CW-1:0]    r_cnt;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_val;
   logic [WIDTH-1:0] w_val_nx;

   always_comb begin
      case (r_op)
         OP_LSH:  w_val_nx = r_val << 1;
         OP_RSH:  w_val_nx = r_val >> 1;
         default: w_val_nx = {r_val[WIDTH-1], r_val[WIDTH-1:1]};
      endcase
   end

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] r_prod;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] w_prod_nx;

   assign w_prod_nx = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
   assign o_is_mul  = (r_op == OP_MUL);
   assign o_result  = o_is_mul ? w_prod_nx[WIDTH-1:0] : w_val_nx;
   assign o_hi_nz   = o_is_mul && (w_prod_nx[2*WIDTH-1:WIDTH] != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (i_load) begin
         r_prod   <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_mplier <= i_mplier;
      end else if (r_cnt != '0) begin
         r_prod   <= w_prod_nx;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
      end
   end
`else
   assign o_is_mul = 1'b0;
   assign o_result = w_val_nx;
   assign o_hi_nz  = 1'b0;
`endif

   // o_result is the value after the step in progress, so it is final when the count reaches one.
   assign o_last = (r_cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_op  <= OP_LSH;
         r_val <= '0;
      end else if (i_load) begin
         r_op  <= i_op;
         r_val <= i_a;
`ifdef ALU_MUL_EN
         r_cnt <= (i_op == OP_MUL) ? CW'(WIDTH) : {1'b0, i_amt};
`else
         r_cnt <= {1'b0, i_amt};
`endif
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CW'(1);
         r_val <= w_val_nx;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle ops inline, shifts/multiply via alu_iter (MUL with ALU_MUL_EN)
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       flags
);

   localparam int MSB = WIDTH - 1;

   state_e           r_state;
   logic             r_ready;
   logic             r_done;
   logic [WIDTH-1:0] r_result;
   logic [4:0]       r_flags;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic [4:0]       w_flg;
   logic             w_single;
   logic             w_multi;
   logic             w_zn;
   logic             w_accept;
   logic             w_load;

   logic             w_it_last;
   logic             w_it_mul;
   logic             w_it_hi_nz;
   logic [WIDTH-1:0] w_it_res;
   logic [4:0]       w_it_flg;

   assign w_accept = start && (r_state == S_IDLE);
   assign w_load   = w_accept && w_multi;

   always_comb begin
      w_sum    = '0;
      w_res    = r_result;
      w_flg    = '0;
      w_single = 1'b1;
      w_multi  = 1'b0;
      w_zn     = 1'b1;
      case (op)
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_XOR:  w_res = a ^ b;
         OP_NOT:  w_res = ~a;
         OP_MOV:  w_res = a;
         OP_ADD, OP_ADDC: begin
            w_sum = {1'b0, a} + {1'b0, b}
                  + {{WIDTH{1'b0}}, (op == OP_ADDC) & r_flags[FLAG_C]};
            w_res = w_sum[MSB:0];
            w_flg[FLAG_C] = w_sum[WIDTH];
            w_flg[FLAG_F] = (a[MSB] == b[MSB]) && (w_res[MSB] != a[MSB]);
         end
         OP_SUB: begin
            // Bit WIDTH of the widened difference is the borrow.
            w_sum = {1'b0, a} - {1'b0, b};
            w_res = w_sum[MSB:0];
            w_flg[FLAG_C] = w_sum[WIDTH];
            w_flg[FLAG_F] = (a[MSB] != b[MSB]) && (w_res[MSB] != a[MSB]);
         end
         OP_CMP: begin
            w_zn          = 1'b0;
            w_flg[FLAG_Z] = (a == b);
            w_flg[FLAG_N] = $signed(a) < $signed(b);
            w_flg[FLAG_L] = (a < b);
         end
         OP_LSH, OP_RSH, OP_ARSH: begin
            if (b[SHW-1:0] != '0) begin
               w_single = 1'b0;
               w_multi  = 1'b1;
            end else begin
               w_res = a;
            end
         end
`ifdef ALU_MUL_EN
         OP_MUL: begin
            w_single = 1'b0;
            w_multi  = 1'b1;
         end
`endif
         default: w_single = 1'b0;
      endcase
      if (w_zn) begin
         w_flg[FLAG_Z] = (w_res == '0);
         w_flg[FLAG_N] = w_res[MSB];
      end
   end

   alu_iter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_iter (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load),
      .i_op     (op),
      .i_a      (a),
      .i_amt    (b[SHW-1:0]),
`ifdef ALU_MUL_EN
      .i_mplier (b),
`endif
      .o_last   (w_it_last),
      .o_is_mul (w_it_mul),
      .o_result (w_it_res),
      .o_hi_nz  (w_it_hi_nz)
   );

   always_comb begin
      w_it_flg = '0;
      w_it_flg[FLAG_Z] = (w_it_res == '0);
      if (w_it_mul) begin
         w_it_flg[FLAG_C] = w_it_hi_nz;
      end else begin
         w_it_flg[FLAG_N] = w_it_res[MSB];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_single) begin
                  r_result <= w_res;
                  r_flags  <= w_flg;
                  r_done   <= 1'b1;
               end else if (w_load) begin
                  r_state <= S_BUSY;
                  r_ready <= 1'b0;
               end
            end
            S_BUSY: begin
               if (w_it_last) begin
                  r_result <= w_it_res;
                  r_flags  <= w_it_flg;
                  r_done   <= 1'b1;
                  r_state  <= S_IDLE;
                  r_ready  <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready  = r_ready;
   assign done   = r_done;
   assign result = r_result;
   assign flags  = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized scoreboard bench for alu_seq, WIDTH=16 (MUL checked when ALU_MUL_EN is defined)
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [3:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          ready;
   logic          done;
   logic [W-1:0]  result;
   logic [4:0]    flags;

   alu_seq #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .ready  (ready),
      .done   (done),
      .result (result),
      .flags  (flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [15:0] res;
      logic [4:0]  flg;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          busy_until = 0;
   bit          mon_en = 1'b0;
   logic [15:0] v_res = '0;
   logic [4:0]  v_flg = '0;
   logic [15:0] m_res = '0;
   logic [4:0]  m_flg = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h required %0h", nm, cyc, act, exp);
      end
   endtask

   // Flag vector layout: [4]=Z [3]=C [2]=F [1]=N [0]=L. Returns 0 for an op the ALU must ignore.
   function automatic bit ref_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                                 input logic cin, input logic [15:0] prev,
                                 output int lat, output logic [15:0] r, output logic [4:0] f);
      longint u;
      longint s;
      int     n;
      lat = 0;
      r   = prev;
      f   = '0;
      n   = int'(y[3:0]);
      case (o)
         OP_AND: r = x & y;
         OP_OR:  r = x | y;
         OP_XOR: r = x ^ y;
         OP_NOT: r = ~x;
         OP_MOV: r = x;
         OP_ADD, OP_ADDC: begin
            u = longint'(x) + longint'(y) + ((o == OP_ADDC) ? longint'(cin) : 0);
            s = longint'($signed(x)) + longint'($signed(y)) + ((o == OP_ADDC) ? longint'(cin) : 0);
            r = 16'(u);
            f[3] = (u > 65535);
            f[2] = (s > 32767) || (s < -32768);
         end
         OP_SUB: begin
            s = longint'($signed(x)) - longint'($signed(y));
            r = x - y;
            f[3] = (x < y);
            f[2] = (s > 32767) || (s < -32768);
         end
         OP_CMP: begin
            f[4] = (x == y);
            f[1] = ($signed(x) < $signed(y));
            f[0] = (x < y);
            return 1'b1;
         end
         OP_LSH:  begin r = x << n; lat = n; end
         OP_RSH:  begin r = x >> n; lat = n; end
         OP_ARSH: begin r = $signed(x) >>> n; lat = n; end
`ifdef ALU_MUL_EN
         OP_MUL: begin
            u = longint'(x) * longint'(y);
            r = 16'(u);
            f[3] = ((u >> 16) != 0);
            f[4] = (r == 16'h0);
            lat = 16;
            return 1'b1;
         end
`endif
         default: return 1'b0;
      endcase
      f[4] = (r == 16'h0);
      f[1] = r[15];
      return 1'b1;
   endfunction

   task automatic step(input bit st, input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input bit rs, input bit ov, input logic [15:0] er, input logic [4:0] ef);
      int          lat;
      logic [15:0] r;
      logic [4:0]  f;
      exp_t        e;
      @(negedge clk);
      #1;
      start = st;
      op    = o;
      a     = x;
      b     = y;
      reset = rs;
      if (rs) begin
         @(posedge clk);
         #1;
         q.delete();
         v_res = '0;
         v_flg = '0;
         m_res = '0;
         m_flg = '0;
         busy_until = cyc;
      end else if (st && (cyc >= busy_until)) begin
         if (ref_op(o, x, y, m_flg[3], m_res, lat, r, f)) begin
            if (ov) begin
               r = er;
               f = ef;
            end
            e.cyc = cyc + 1 + lat;
            e.res = r;
            e.flg = f;
            q.push_back(e);
            busy_until = e.cyc;
            m_res = r;
            m_flg = f;
         end
      end
   endtask

   task automatic go(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
      step(1'b1, o, x, y, 1'b0, 1'b0, 16'h0, 5'h0);
   endtask

   task automatic gox(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] er, input logic [4:0] ef);
      step(1'b1, o, x, y, 1'b0, 1'b1, er, ef);
   endtask

   // Idle cycles still scramble op/a/b so in-flight operations must rely on captured operands.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0, 5'h0);
      end
   endtask

   task automatic do_reset(input bit st);
      step(st, OP_ADD, 16'h1234, 16'h0001, 1'b1, 1'b0, 16'h0, 5'h0);
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h7FFF;
         3:       return 16'h8000;
         4:       return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   // Monitor: pops the scoreboard on the cycle a done is due and checks held outputs every cycle.
   initial begin
      exp_t e;
      bit   exp_done;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
               checks++;
               errors++;
               $display("FAIL done_missing at cycle %0d: got no done required done at cycle %0d", cyc, q[0].cyc);
               e = q.pop_front();
            end
            exp_done = (q.size() > 0) && (q[0].cyc == cyc);
            chk("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
               e = q.pop_front();
               v_res = e.res;
               v_flg = e.flg;
            end
            chk("result", 32'(result), 32'(v_res));
            chk("flags", 32'(flags), 32'(v_flg));
            chk("ready", 32'(ready), 32'(cyc >= busy_until));
         end
      end
   end

   initial begin
      int drain;
      reset = 1'b1;
      start = 1'b0;
      op    = 4'h0;
      a     = '0;
      b     = '0;
      do_reset(1'b0);
      do_reset(1'b0);
      mon_en = 1'b1;
      idle(2);

      gox(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 5'b00110);
      idle(1);
      gox(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 5'b11000);
      gox(OP_ADDC, 16'h0000, 16'h0000, 16'h0001, 5'b00000);
      gox(OP_CMP, 16'hFFFF, 16'h0001, 16'h0001, 5'b00010);
      idle(1);
      gox(OP_ARSH, 16'h8004, 16'h0002, 16'hE001, 5'b00010);
      go(OP_ADD, 16'h0001, 16'h0001);
      idle(3);
      gox(OP_LSH, 16'h1234, 16'h0010, 16'h1234, 5'b00000);
      gox(OP_RSH, 16'h8000, 16'h000F, 16'h0001, 5'b00000);
      idle(16);
      gox(OP_ARSH, 16'h8000, 16'h000F, 16'hFFFF, 5'b00010);
      idle(16);
      go(OP_LSH, 16'h0001, 16'h000F);
      idle(3);
      do_reset(1'b1);
      idle(20);
      go(4'd13, 16'h5555, 16'h1111);
      go(4'd15, 16'h5555, 16'h1111);
      idle(2);
`ifdef ALU_MUL_EN
      gox(OP_MUL, 16'h0100, 16'h0100, 16'h0000, 5'b11000);
`else
      go(OP_MUL, 16'h0100, 16'h0100);
`endif
      idle(20);

      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), pick(), pick(),
              ($urandom_range(0, 149) == 0), 1'b0, 16'h0, 5'h0);
      end

      drain = 0;
      while (q.size() > 0 && drain < 100) begin
         idle(1);
         drain++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending results required 0", q.size());
      end
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width (legal 8..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; accepted only when ready=1.
REQ-006 SHALL have port op  input  4  operation code (alu_pkg encoding).
REQ-007 SHALL have ports a, b  input  WIDTH  operands.
REQ-008 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-009 SHALL have port done  output  1  one-cycle pulse: result and flags valid.
REQ-010 SHALL have port result  output  WIDTH  registered result, held until next done.
REQ-011 SHALL have port flags  output  5  registered ZCFNL (4 Z, 3 C, 2 F overflow, 1 N, 0 L).

Function
REQ-012 SHALL implement a 2-state FSM: IDLE (ready=1), BUSY (ready=0).
REQ-013 Single-cycle ops (AND, OR, XOR, NOT, ADD, ADDC, SUB, CMP, MOV): start in IDLE -> result/flags/done on the next edge; FSM stays IDLE; back-to-back starts accepted every cycle.
REQ-014 Multi-cycle ops (LSH, RSH, ARSH by b[SHW-1:0]; MUL if enabled): start in IDLE -> BUSY; one bit of shift (or one multiplier bit) per cycle; done pulses on the edge that returns to IDLE.
REQ-015 Shift amount 0 SHALL complete in 1 cycle with result=a; amount n SHALL take n cycles.
REQ-016 start while BUSY, or with an undefined op, SHALL be ignored: no done, registers unchanged.
REQ-017 Operands SHALL be captured at acceptance; later changes on a/b/op do not affect the operation in flight.
REQ-018 ADD/SUB/ADDC SHALL compute modulo 2^WIDTH; C=carry-out (SUB: C=borrow, i.e. a<b unsigned); F=signed overflow; N=result MSB; L=0.
REQ-019 ADDC SHALL use the current flags C bit as carry-in (multi-word chaining).
REQ-020 CMP SHALL leave result unchanged; Z=(a==b), N=signed a<b, L=unsigned a<b, C=F=0.
REQ-021 Logic, MOV, shifts SHALL set Z=(result==0), N=result MSB, C=F=L=0; ARSH replicates MSB; LSH/RSH fill zero.
REQ-022 flags and result SHALL update only on done; in between they hold.

Reset
REQ-023 reset SHALL force IDLE, result=0, flags=0, done=0, ready=1 on the next edge, aborting any BUSY operation without a done pulse.
REQ-024 reset SHALL take priority over a simultaneous start.

Configuration
REQ-025 With ALU_MUL_EN defined, op MUL SHALL perform unsigned shift-add multiply in WIDTH cycles, result=low WIDTH bits, C=(high half!=0), Z on low half, F=N=L=0.
REQ-026 Without ALU_MUL_EN, MUL SHALL be an undefined op (ignored per REQ-016) and no multiplier logic is synthesised.

Structure
REQ-027 Package alu_pkg SHALL hold the op enum (AND, OR, XOR, NOT, ADD, ADDC, SUB, CMP, MOV, LSH, RSH, ARSH, MUL) and flag index constants FLAG_Z..FLAG_L.
REQ-028 Iterative shift/multiply datapath and its cycle counter SHALL be sub-module alu_iter; combinational single-cycle ops stay in alu_seq.

Verification (WIDTH=16)
REQ-029 ADD a=0x7FFF b=0x0001 -> 1 cycle later done, result 0x8000, flags F=1 N=1 C=0 Z=0.
REQ-030 ADD 0xFFFF+0x0001 then ADDC 0x0000+0x0000 back-to-back -> results 0x0000 (Z=1 C=1) then 0x0001.
REQ-031 CMP a=0xFFFF b=0x0001 -> N=0? no: N=1 (signed -1<1), L=0, Z=0, result unchanged.
REQ-032 ARSH a=0x8004 b=2 -> ready low 2 cycles, start during BUSY ignored, done with 0xE001.
REQ-033 LSH a=0x0001 b=15, reset asserted at cycle 5 -> no done, result 0, flags 0, ready=1.
REQ-034 With ALU_MUL_EN: MUL 0x0100*0x0100 -> done after 16 cycles, result 0x0000, C=1, Z=1; without macro: no done.
